// File: rtl/neighbor_reader_if.sv
// Request and neighbor-stream handshake bundle for neighbor_reader.
// The slave side is the reader and the master side is the requester/consumer.
interface neighbor_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vertex;
    logic        nb_valid;
    logic        nb_ready;
    logic [31:0] nb_vertex;
    logic        nb_last;
    logic [3:0]  nb_count;

    modport master (
        output req_valid, req_vertex, nb_ready,
        input  req_ready, nb_valid, nb_vertex, nb_last, nb_count
    );

    modport slave (
        input  req_valid, req_vertex, nb_ready,
        output req_ready, nb_valid, nb_vertex, nb_last, nb_count
    );
endinterface

// File: rtl/neighbor_reader.sv
// Fetches a 1-indexed vertex's neighbor list from the neighbor RAM and streams
// it out one index per beat, flagging the last beat and pulsing done at the end.
module neighbor_reader #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int LIST_STRIDE        = 11,
    parameter int MAX_VERTEX         = 46
) (
    input  logic              clk,
    input  logic              rst,
    neighbor_reader_if.slave  bus,
    output logic              done,
    output logic              err_bad_vertex,
    output logic              err_overflow,
    output logic              RAM_EN,
    output logic [8:0]        RAM_A,
    output logic [3:0]        RAM_WE,
    output logic [31:0]       RAM_Di,
    input  logic [31:0]       RAM_Do
);
    typedef enum logic [2:0] {IDLE, RD_CNT, FETCH, PRESENT, FINISH} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_NEIGHBOR_COUNT);

    state_t      state_q, state_d;
    logic [8:0]  base_q, base_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        nb_valid_q, nb_valid_d;
    logic        nb_last_q, nb_last_d;
    logic [31:0] nb_vertex_q, nb_vertex_d;
    logic [3:0]  nb_count_q, nb_count_d;
    logic        done_q, done_d;
    logic        err_bad_q, err_bad_d;
    logic        err_ovf_q, err_ovf_d;
    logic        ram_en_q, ram_en_d;
    logic [8:0]  ram_a_q, ram_a_d;

    logic        accept;
    logic        bad_vertex;
    logic        handshake;
    logic        last_idx;
    logic [3:0]  raw_cnt;
    logic        cnt_over;
    logic [3:0]  clamped_cnt;
    logic [8:0]  req_base;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bad_vertex    = (bus.req_vertex == 32'd0) || (bus.req_vertex > 32'(MAX_VERTEX));
    assign handshake     = nb_valid_q && bus.nb_ready;
    assign last_idx      = (idx_q == cnt_q);
    assign raw_cnt       = RAM_Do[3:0];
    assign cnt_over      = (raw_cnt > MAX_CNT);
    assign clamped_cnt   = cnt_over ? MAX_CNT : raw_cnt;
    // Only meaningful for legal vertices, where the product fits in 9 bits.
    assign req_base      = 9'((bus.req_vertex[8:0] - 9'd1) * 9'(LIST_STRIDE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bad_vertex ? FINISH : RD_CNT;
            RD_CNT:  state_d = (clamped_cnt == 4'd0) ? FINISH : FETCH;
            FETCH:   state_d = PRESENT;
            PRESENT: if (handshake) state_d = last_idx ? FINISH : FETCH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q (done from 0) so no branch can infer a latch.
        base_d      = base_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        nb_valid_d  = nb_valid_q;
        nb_last_d   = nb_last_q;
        nb_vertex_d = nb_vertex_q;
        nb_count_d  = nb_count_q;
        done_d      = 1'b0;
        err_bad_d   = err_bad_q;
        err_ovf_d   = err_ovf_q;
        ram_en_d    = ram_en_q;
        ram_a_d     = ram_a_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d    = req_base;
                    err_bad_d = 1'b0;
                    err_ovf_d = 1'b0;
                    if (bad_vertex) begin
                        err_bad_d  = 1'b1;
                        nb_count_d = 4'd0;
                    end else begin
                        ram_a_d  = req_base;
                        ram_en_d = 1'b1;
                    end
                end
            end
            RD_CNT: begin
                cnt_d      = clamped_cnt;
                nb_count_d = clamped_cnt;
                err_ovf_d  = cnt_over;
                if (clamped_cnt == 4'd0) begin
                    // Empty list: nothing more to read, so release the RAM now.
                    ram_en_d = 1'b0;
                end else begin
                    idx_d   = 4'd1;
                    ram_a_d = base_q + 9'd1;
                end
            end
            FETCH: begin
                nb_vertex_d = RAM_Do;
                nb_valid_d  = 1'b1;
                nb_last_d   = last_idx;
                ram_en_d    = 1'b0;
            end
            PRESENT: begin
                if (handshake) begin
                    nb_valid_d = 1'b0;
                    nb_last_d  = 1'b0;
                    if (!last_idx) begin
                        idx_d    = idx_q + 4'd1;
                        ram_a_d  = base_q + 9'(idx_q) + 9'd1;
                        ram_en_d = 1'b1;
                    end
                end
            end
            FINISH:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            nb_valid_q  <= 1'b0;
            nb_last_q   <= 1'b0;
            nb_vertex_q <= '0;
            nb_count_q  <= '0;
            done_q      <= 1'b0;
            err_bad_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_a_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            nb_valid_q  <= nb_valid_d;
            nb_last_q   <= nb_last_d;
            nb_vertex_q <= nb_vertex_d;
            nb_count_q  <= nb_count_d;
            done_q      <= done_d;
            err_bad_q   <= err_bad_d;
            err_ovf_q   <= err_ovf_d;
            ram_en_q    <= ram_en_d;
            ram_a_q     <= ram_a_d;
        end
    end

    assign bus.nb_valid  = nb_valid_q;
    assign bus.nb_last   = nb_last_q;
    assign bus.nb_vertex = nb_vertex_q;
    assign bus.nb_count  = nb_count_q;
    assign done          = done_q;
    assign err_bad_vertex = err_bad_q;
    assign err_overflow  = err_ovf_q;
    assign RAM_EN        = ram_en_q;
    assign RAM_A         = ram_a_q;
    assign RAM_WE        = 4'd0;
    assign RAM_Di        = 32'd0;
endmodule

// File: tb/tb_neighbor_reader.sv
// Scoreboard bench for neighbor_reader: requests push expected beats/completions
// computed from the RAM image; a monitor pops and compares on every handshake/done.
module tb_neighbor_reader;
    localparam int MAXN   = 10;
    localparam int STRIDE = 11;
    localparam int MAXV   = 46;

    typedef struct packed {
        logic [31:0] vertex;
        logic        last;
        logic [3:0]  count;
    } beat_t;

    typedef struct packed {
        logic        bad;
        logic        ovf;
        logic [3:0]  count;
    } cmpl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        done, err_bad_vertex, err_overflow;
    logic        ram_en;
    logic [8:0]  ram_a;
    logic [3:0]  ram_we;
    logic [31:0] ram_di, ram_do;
    logic [31:0] mem [0:511];

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode;
    logic manual_ready;

    beat_t exp_q[$];
    cmpl_t cmpl_q[$];

    always #5 clk = ~clk;

    neighbor_reader_if bus();

    neighbor_reader u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .done           (done),
        .err_bad_vertex (err_bad_vertex),
        .err_overflow   (err_overflow),
        .RAM_EN         (ram_en),
        .RAM_A          (ram_a),
        .RAM_WE         (ram_we),
        .RAM_Di         (ram_di),
        .RAM_Do         (ram_do)
    );

    // Read data follows the registered address within the same cycle.
    assign ram_do = ram_en ? mem[ram_a] : 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] v);
        return (v == 32'd0) || (v > 32'(MAXV));
    endfunction

    function automatic logic [3:0] raw_count(input logic [31:0] v);
        logic [31:0] w;
        w = mem[(int'(v) - 1) * STRIDE];
        return w[3:0];
    endfunction

    function automatic int model_count(input logic [31:0] v);
        int r;
        if (is_bad(v)) return 0;
        r = int'(raw_count(v));
        return (r > MAXN) ? MAXN : r;
    endfunction

    function automatic int exp_latency(input logic [31:0] v);
        int c;
        if (is_bad(v)) return 1;
        c = model_count(v);
        return (c == 0) ? 2 : 2 * c + 2;
    endfunction

    task automatic expect_req(input logic [31:0] v);
        int c, base;
        beat_t b;
        cmpl_t m;
        c = model_count(v);
        base = is_bad(v) ? 0 : (int'(v) - 1) * STRIDE;
        for (int k = 1; k <= c; k++) begin
            b.vertex = mem[base + k];
            b.last   = (k == c);
            b.count  = 4'(c);
            exp_q.push_back(b);
        end
        m.bad   = is_bad(v);
        m.ovf   = !is_bad(v) && (int'(raw_count(v)) > MAXN);
        m.count = 4'(c);
        cmpl_q.push_back(m);
    endtask

    // Issues one request and reports cycles (after the accept edge) to first
    // nb_valid and to done, plus whether RAM_EN was ever seen high.
    task automatic do_req(input logic [31:0] v, output int t_first, output int t_done,
                          output logic en_seen);
        int guard;
        expect_req(v);
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_vertex = v;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        en_seen = ram_en;
        t_first = -1;
        t_done  = -1;
        for (int c = 1; c < 400 && t_done < 0; c++) begin
            @(posedge clk);
            #1;
            if (ram_en) en_seen = 1'b1;
            if (bus.nb_valid && t_first < 0) t_first = c;
            if (done) t_done = c;
        end
        if (t_done < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.nb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.nb_ready = 1'b1;
                1:       bus.nb_ready = 1'($urandom_range(0, 1));
                default: bus.nb_ready = manual_ready;
            endcase
        end
    end

    logic        stalled;
    logic [31:0] held_v;
    logic [8:0]  held_a;
    int          beats_seen;

    initial begin
        beat_t b;
        cmpl_t m;
        stalled    = 1'b0;
        beats_seen = 0;
        held_v     = '0;
        held_a     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled    = 1'b0;
                beats_seen = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(bus.nb_valid), 32'd1);
                    check("hold_vertex", bus.nb_vertex, held_v);
                    check("hold_addr", 32'(ram_a), 32'(held_a));
                end
                stalled = bus.nb_valid && !bus.nb_ready;
                held_v  = bus.nb_vertex;
                held_a  = ram_a;
                if (bus.nb_valid && bus.nb_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        b = exp_q.pop_front();
                        check("nb_vertex", bus.nb_vertex, b.vertex);
                        check("nb_last", 32'(bus.nb_last), 32'(b.last));
                        check("nb_count", 32'(bus.nb_count), 32'(b.count));
                    end
                    beats_seen++;
                end
                if (done) begin
                    if (cmpl_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        m = cmpl_q.pop_front();
                        check("beat_count", 32'(beats_seen), 32'(m.count));
                        check("err_bad_vertex", 32'(err_bad_vertex), 32'(m.bad));
                        check("err_overflow", 32'(err_overflow), 32'(m.ovf));
                        check("done_nb_count", 32'(bus.nb_count), 32'(m.count));
                        check("ram_we_zero", 32'(ram_we), 32'd0);
                        check("ram_di_zero", ram_di, 32'd0);
                    end
                    beats_seen = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_nb_valid", 32'(bus.nb_valid), 32'd0);
        check("rst_nb_last", 32'(bus.nb_last), 32'd0);
        check("rst_nb_vertex", bus.nb_vertex, 32'd0);
        check("rst_nb_count", 32'(bus.nb_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_bad", 32'(err_bad_vertex), 32'd0);
        check("rst_err_ovf", 32'(err_overflow), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_a", 32'(ram_a), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_di", ram_di, 32'd0);
    endtask

    initial begin
        int t_first, t_done, guard, exp_c;
        logic en_seen;
        logic [31:0] v, w;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_vertex = '0;
        ready_mode     = 0;
        manual_ready   = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[11] = 32'h5A5A_0003;
        mem[12] = 32'd7;
        mem[13] = 32'd2;
        mem[14] = 32'd9;
        mem[44] = 32'd15;
        for (int k = 1; k <= 10; k++) mem[44 + k] = 32'(1000 + k);

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        #1;
        check("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

        do_req(32'd2, t_first, t_done, en_seen);
        check("v2_first_latency", 32'(t_first), 32'd2);
        check("v2_done_latency", 32'(t_done), 32'd8);

        do_req(32'd1, t_first, t_done, en_seen);
        check("empty_no_valid", 32'(t_first), 32'hFFFF_FFFF);
        check("empty_done_latency", 32'(t_done), 32'd2);

        do_req(32'd0, t_first, t_done, en_seen);
        check("v0_done_latency", 32'(t_done), 32'd1);
        check("v0_no_ram_en", 32'(en_seen), 32'd0);
        do_req(32'd47, t_first, t_done, en_seen);
        check("v47_done_latency", 32'(t_done), 32'd1);
        check("v47_no_ram_en", 32'(en_seen), 32'd0);

        do_req(32'd5, t_first, t_done, en_seen);
        check("ovf_done_latency", 32'(t_done), 32'd22);

        // Backpressure on beat 2 of vertex 2.
        ready_mode   = 2;
        manual_ready = 1'b1;
        fork
            do_req(32'd2, t_first, t_done, en_seen);
            begin
                guard = 0;
                @(negedge clk);
                while (!(bus.nb_valid && bus.nb_vertex == 32'd7) && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                @(negedge clk);
                manual_ready = 1'b0;
                guard = 0;
                while (!bus.nb_valid && guard < 10) begin
                    @(negedge clk);
                    guard++;
                end
                for (int s = 0; s < 5; s++) begin
                    check("stall_vertex", bus.nb_vertex, 32'd2);
                    check("stall_valid", 32'(bus.nb_valid), 32'd1);
                    @(negedge clk);
                end
                manual_ready = 1'b1;
            end
        join

        // Reset while the first beat is being presented.
        ready_mode   = 2;
        manual_ready = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_vertex = 32'd2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.nb_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("abort_beat1_vertex", bus.nb_vertex, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (4) @(negedge clk);
        ready_mode = 0;
        do_req(32'd2, t_first, t_done, en_seen);
        check("post_abort_done_latency", 32'(t_done), 32'd8);

        // Randomized lists, vertices and backpressure.
        for (int i = 0; i < 506; i++) mem[i] = $urandom;
        for (int vv = 1; vv <= MAXV; vv++) begin
            w = $urandom;
            w[3:0] = 4'($urandom_range(0, 15));
            mem[(vv - 1) * STRIDE] = w;
        end
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       v = 32'd0;
                1:       v = $urandom;
                2:       v = 32'($urandom_range(47, 600));
                default: v = 32'($urandom_range(1, MAXV));
            endcase
            ready_mode = int'($urandom_range(0, 1));
            do_req(v, t_first, t_done, en_seen);
            if (ready_mode == 0) begin
                exp_c = model_count(v);
                check("rnd_done_latency", 32'(t_done), 32'(exp_latency(v)));
                check("rnd_first_latency", 32'(t_first), (exp_c > 0) ? 32'd2 : 32'hFFFF_FFFF);
            end
            if (is_bad(v)) check("rnd_bad_no_ram_en", 32'(en_seen), 32'd0);
        end

        repeat (4) @(negedge clk);
        check("beats_drained", 32'(exp_q.size()), 32'd0);
        check("cmpl_drained", 32'(cmpl_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
